// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULTU/DIVU controller for the EX stage.
// It has no adder of its own. Each cycle it borrows the shared ALU for one
// add (shift-add multiply) or one subtract (restoring divide), and it keeps
// the partial results in HI/LO.
module muldiv_sequencer #(
    parameter int                WIDTH     = 32,
    parameter logic [WIDTH-1:0]  DIV0_QUOT = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] alu_src_a,
    output logic [WIDTH-1:0] alu_src_b,
    output logic [4:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result
);

    // Shared ALU control encodings (only add and sub are ever driven).
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   opb_q, opb_d;   // multiplier M or divisor D
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic               last_iter;
    logic               mul_carry;
    logic               r_top;
    logic [WIDTH-1:0]   r_rem;
    logic               sub_ok;

    // A request is taken only from IDLE, and flush always beats start.
    assign accept    = (state_q == S_IDLE) && start && !flush;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Multiply: the ALU adds hi + M. An unsigned wrap shows up as a result
    // smaller than hi, and that is the carry into the 65-bit shift.
    assign mul_carry = (alu_result < hi_q);

    // Divide: shift the partial remainder left by one and pull in the next
    // dividend bit from lo. The bit that falls out of hi (r_top) means the
    // 33-bit remainder is certainly >= D.
    assign r_top  = hi_q[WIDTH-1];
    assign r_rem  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign sub_ok = r_top || (r_rem >= opb_q);

    // ALU operand and control drive. Only MUL and DIV use the ALU.
    always_comb begin
        alu_src_a   = '0;
        alu_src_b   = '0;
        alu_control = ALU_ADD;
        case (state_q)
            S_MUL: begin
                alu_src_a   = hi_q;
                alu_src_b   = opb_q;
                alu_control = ALU_ADD;
            end
            S_DIV: begin
                alu_src_a   = r_rem;
                alu_src_b   = opb_q;
                alu_control = ALU_SUB;
            end
            default: ;
        endcase
    end

    // Next-state logic and the HI/LO/counter datapath updates.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    opb_d = operand_b;
                    if (!op) begin
                        state_d = S_MUL;
                        hi_d    = '0;
                        lo_d    = operand_a;
                    end else if (operand_b != '0) begin
                        state_d = S_DIV;
                        hi_d    = '0;
                        lo_d    = operand_a;
                    end else begin
                        // Divide by zero resolves at once, with no ALU work.
                        state_d = S_FIN;
                        hi_d    = operand_a;
                        lo_d    = DIV0_QUOT;
                    end
                end
            end
            S_MUL: begin
                if (lo_q[0]) begin
                    {hi_d, lo_d} = {mul_carry, alu_result, lo_q[WIDTH-1:1]};
                end else begin
                    {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = S_FIN;
                    cnt_d   = '0;
                end
            end
            S_DIV: begin
                if (sub_ok) begin
                    hi_d = alu_result;
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = r_rem;
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = S_FIN;
                    cnt_d   = '0;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A kill drops the operation. HI/LO simply hold, and software must
        // not rely on them after a flush.
        if (flush && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            cnt_d   = '0;
        end
    end

    // State, HI/LO, latched operand and iteration counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall starts in the issue cycle itself, and a killed FIN reports no done.
    assign busy = (state_q != S_IDLE) || accept;
    assign done = (state_q == S_FIN) && !flush;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer. It uses a behavioural ALU, a
// directed vector table, hand-written flush/reset sequences and random ops
// checked against plain-arithmetic results.
module tb_muldiv_sequencer;

    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        busy, done;
    logic [31:0] hi, lo, alu_src_a, alu_src_b, alu_result;
    logic [4:0]  alu_control;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Shared ALU model.
    assign alu_result = (alu_control == ALU_SUB) ? (alu_src_a - alu_src_b)
                                                 : (alu_src_a + alu_src_b);

    muldiv_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .alu_result(alu_result)
    );

    typedef struct {
        string       name;
        logic        op;
        logic [31:0] a, b;
        logic [31:0] exp_hi, exp_lo;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference results from plain arithmetic.
    task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l, output int lat);
        logic [63:0] p;
        if (!o) begin
            p = 64'(a) * 64'(b);
            h = p[63:32];
            l = p[31:0];
            lat = 33;
        end else if (b == 0) begin
            h = a;
            l = 32'hFFFFFFFF;
            lat = 1;
        end else begin
            h = a % b;
            l = a / b;
            lat = 33;
        end
    endtask

    // The caller is just after a rising edge. This task issues one op, then
    // watches each cycle for done with a bounded wait. It returns at the
    // falling edge of the done cycle.
    task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] rh, output logic [31:0] rl,
                         output bit busy_ok, output bit sub_seen);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(negedge clk);
        busy_ok  = busy;
        sub_seen = 1'b0;
        lat      = -1;
        rh       = '0;
        rl       = '0;
        @(posedge clk); #1;
        start = 1'b0; operand_a = $urandom; operand_b = $urandom;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (alu_control == ALU_SUB) sub_seen = 1'b1;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k;
                rh  = hi;
                rl  = lo;
                break;
            end
        end
    endtask

    task automatic run_chk(input string nm, input logic o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh,
                           input logic [31:0] el, input int elat);
        int lat;
        logic [31:0] rh, rl;
        bit bok, sub;
        @(posedge clk); #1;
        do_op(o, a, b, lat, rh, rl, bok, sub);
        chk({nm, " latency"}, 64'(lat), 64'(elat));
        chk({nm, " hi"}, 64'(rh), 64'(eh));
        chk({nm, " lo"}, 64'(rl), 64'(el));
        chk({nm, " busy held"}, 64'(bok), 64'd1);
        if (o && b == 0) chk({nm, " no sub"}, 64'(sub), 64'd0);
        @(posedge clk); #1;
        chk({nm, " done pulse"}, 64'(done), 64'd0);
        chk({nm, " busy clear"}, 64'(busy), 64'd0);
        chk({nm, " hi stable"}, 64'(hi), 64'(eh));
        chk({nm, " lo stable"}, 64'(lo), 64'(el));
    endtask

    // Count done pulses over a fixed window; none are expected.
    task automatic no_done(input string nm, input int cycles);
        int cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk({nm, " stray done"}, 64'(cnt), 64'd0);
    endtask

    initial begin
        vec_t        tbl[10];
        int          lat;
        logic [31:0] rh, rl, eh, el;
        bit          bok, sub;
        logic        o;
        logic [31:0] a, b;
        int          elat;

        tbl[0] = '{"mul 7x6",        1'b0, 32'd7,        32'd6,        32'h0,        32'h2A,       33};
        tbl[1] = '{"mul ff x ff",    1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1,        33};
        tbl[2] = '{"mul 8000 x 2",   1'b0, 32'h80000000, 32'd2,        32'h1,        32'h0,        33};
        tbl[3] = '{"mul 0 x ff",     1'b0, 32'd0,        32'hFFFFFFFF, 32'h0,        32'h0,        33};
        tbl[4] = '{"div 100/7",      1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       33};
        tbl[5] = '{"div 8000/3",     1'b1, 32'h80000000, 32'd3,        32'd2,        32'h2AAAAAAA, 33};
        tbl[6] = '{"div 5/9",        1'b1, 32'd5,        32'd9,        32'd5,        32'd0,        33};
        tbl[7] = '{"div 1234/0",     1'b1, 32'd1234,     32'd0,        32'd1234,     32'hFFFFFFFF, 1};
        tbl[8] = '{"div ff/1",       1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 33};
        tbl[9] = '{"div ff/8..1",    1'b1, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'd1,        33};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset alu a", 64'(alu_src_a), 64'd0);
        chk("reset alu b", 64'(alu_src_b), 64'd0);
        chk("reset alu ctl", 64'(alu_control), 64'(ALU_ADD));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 10; i++)
            run_chk(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b,
                    tbl[i].exp_hi, tbl[i].exp_lo, tbl[i].exp_lat);

        // Flush during MULTU iteration 10, then an immediate DIVU 9/2.
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; operand_a = 32'd123; operand_b = 32'd456;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        #1;
        chk("flush mul busy", 64'(busy), 64'd1);
        chk("flush mul done", 64'(done), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        chk("after flush busy", 64'(busy), 64'd0);
        chk("after flush done", 64'(done), 64'd0);
        do_op(1'b1, 32'd9, 32'd2, lat, rh, rl, bok, sub);
        chk("div 9/2 latency", 64'(lat), 64'd33);
        chk("div 9/2 hi", 64'(rh), 64'd1);
        chk("div 9/2 lo", 64'(rl), 64'd4);

        // Flush in the FIN cycle of a divide-by-zero suppresses done.
        @(posedge clk); #1;
        start = 1'b1; op = 1'b1; operand_a = 32'd5; operand_b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b1;
        #1;
        chk("flush fin done", 64'(done), 64'd0);
        chk("flush fin busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        chk("flush fin idle", 64'(busy), 64'd0);

        // start and flush together in IDLE: the request is dropped.
        start = 1'b1; op = 1'b0; operand_a = 32'd3; operand_b = 32'd3; flush = 1'b1;
        #1;
        chk("start+flush busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        #1;
        chk("start+flush dropped", 64'(busy), 64'd0);
        no_done("start+flush", 40);

        // A start while busy is ignored and not queued.
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; operand_a = 32'd3; operand_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 start = 1'b1; op = 1'b1; operand_a = 32'd77; operand_b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                rh  = hi;
                rl  = lo;
                break;
            end
        end
        chk("busy start seen done", 64'(lat >= 0), 64'd1);
        chk("busy start hi", 64'(rh), 64'd0);
        chk("busy start lo", 64'(rl), 64'd15);
        no_done("busy start", 40);

        // Reset asserted mid-DIV after an ignored start.
        @(posedge clk); #1;
        start = 1'b1; op = 1'b1; operand_a = 32'd1000; operand_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset busy", 64'(busy), 64'd0);
        chk("mid reset done", 64'(done), 64'd0);
        chk("mid reset hi", 64'(hi), 64'd0);
        chk("mid reset lo", 64'(lo), 64'd0);
        chk("mid reset alu a", 64'(alu_src_a), 64'd0);
        chk("mid reset alu b", 64'(alu_src_b), 64'd0);
        chk("mid reset alu ctl", 64'(alu_control), 64'(ALU_ADD));
        @(posedge clk); #1;
        rst_n = 1'b1;
        no_done("mid reset", 40);

        // Randomized ops against the arithmetic reference.
        for (int i = 0; i < 30; i++) begin
            o = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            model(o, a, b, eh, el, elat);
            run_chk($sformatf("rand%0d %s %h,%h", i, o ? "div" : "mul", a, b),
                    o, a, b, eh, el, elat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
